gcd_engine: RTL and testbench



---
 rtl/gcd_engine_if.sv | 42 ++++
 rtl/gcd_engine.sv | 117 +++++++++++
 tb/tb_gcd_engine.sv | 269 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/gcd_engine_if.sv
// Handshake bundle for gcd_engine: operand side, result side and the abort/status lines.
// The engine connects through the slave modport; the producer/consumer uses master.
interface gcd_engine_if #(
  parameter int WIDTH = 8
);
  logic             clear;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_gcd;
  logic [WIDTH-1:0] out_steps;
  logic             busy;

  modport slave (
    input  clear,
    input  in_valid,
    input  in_a,
    input  in_b,
    input  out_ready,
    output in_ready,
    output out_valid,
    output out_gcd,
    output out_steps,
    output busy
  );

  modport master (
    output clear,
    output in_valid,
    output in_a,
    output in_b,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  out_gcd,
    input  out_steps,
    input  busy
  );
endinterface

// File: rtl/gcd_engine.sv
// Single-transaction GCD engine using repeated subtraction.
// One rule is evaluated per cycle in CALC; every output is a flop so nothing
// combinational runs from an input to an output.
module gcd_engine #(
  parameter int WIDTH = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  gcd_engine_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [WIDTH-1:0] STEPS_MAX = '1;
  localparam logic [WIDTH-1:0] ONE       = WIDTH'(1);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] steps_q, steps_d;
  logic [WIDTH-1:0] gcd_q, gcd_d;
  logic [WIDTH-1:0] out_steps_q, out_steps_d;
  logic             in_ready_q, in_ready_d;
  logic             out_valid_q, out_valid_d;
  logic             busy_q, busy_d;

  // Next-state, datapath and registered-output decode; clear overrides everything.
  always_comb begin
    state_d     = state_q;
    a_d         = a_q;
    b_d         = b_q;
    steps_d     = steps_q;
    gcd_d       = gcd_q;
    out_steps_d = out_steps_q;

    if (bus.clear) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (bus.in_valid && in_ready_q) begin
            a_d     = bus.in_a;
            b_d     = bus.in_b;
            steps_d = '0;
            state_d = CALC;
          end
        end
        CALC: begin
          if ((a_q == '0) || (b_q == '0)) begin
            gcd_d       = a_q | b_q;
            out_steps_d = steps_q;
            state_d     = DONE;
          end else if (a_q == b_q) begin
            gcd_d       = a_q;
            out_steps_d = steps_q;
            state_d     = DONE;
          end else begin
            if (a_q > b_q) begin
              a_d = a_q - b_q;
            end else begin
              b_d = b_q - a_q;
            end
            if (steps_q != STEPS_MAX) begin
              steps_d = steps_q + ONE;
            end
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            state_d = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end

    in_ready_d  = (state_d == IDLE);
    busy_d      = (state_d == CALC);
    out_valid_d = (state_d == DONE);
  end

  // State, datapath and output registers with asynchronous reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      a_q         <= '0;
      b_q         <= '0;
      steps_q     <= '0;
      gcd_q       <= '0;
      out_steps_q <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      b_q         <= b_d;
      steps_q     <= steps_d;
      gcd_q       <= gcd_d;
      out_steps_q <= out_steps_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_gcd   = gcd_q;
  assign bus.out_steps = out_steps_q;
  assign bus.busy      = busy_q;

endmodule

// File: tb/tb_gcd_engine.sv
// Scoreboard bench for gcd_engine: the driver pushes a reference result on each
// accepted operand pair; an independent monitor pops and compares when a result appears.
module tb_gcd_engine;

  localparam int W     = 8;
  localparam int LIMIT = 2000;

  typedef struct packed {
    logic [W-1:0] gcd;
    logic [W-1:0] steps;
    int           accept_cycle;
  } exp_t;

  logic clk;
  logic rst_n;
  int   cycle;
  int   compared;
  int   mismatched;
  int   busy_cnt;
  bit   prev_valid;
  exp_t sb_q[$];

  gcd_engine_if #(.WIDTH(W)) bus ();

  gcd_engine #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Free-running clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Edge counter used to measure accept-to-result latency.
  always @(posedge clk) cycle <= cycle + 1;

  // Reference: Euclid by division. Subtraction steps to reach equality are the sum
  // of the quotients minus the final one that would reach zero.
  function automatic void ref_gcd(input int a, input int b, output int g, output int s);
    int x, y, t;
    if (a == 0 || b == 0) begin
      g = a | b;
      s = 0;
      return;
    end
    x = a;
    y = b;
    s = 0;
    while (y != 0) begin
      s = s + x / y;
      t = x % y;
      x = y;
      y = t;
    end
    g = x;
    s = s - 1;
    if (s > (1 << W) - 1) s = (1 << W) - 1;
  endfunction

  task automatic checkOutput(input string name, input int actual, input int expected);
    compared++;
    if (actual != expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, actual, expected, cycle);
    end
  endtask

  task automatic pushExpected(input int a, input int b);
    int g, s;
    exp_t e;
    ref_gcd(a, b, g, s);
    e.gcd          = W'(g);
    e.steps        = W'(s);
    e.accept_cycle = cycle;
    sb_q.push_back(e);
    busy_cnt = 0;
  endtask

  // Waits for in_ready, presents one pair for exactly one accept edge.
  task automatic applyStimulus(input int a, input int b, input bit track);
    int waited = 0;
    @(negedge clk);
    while (!bus.in_ready && waited < LIMIT) begin
      @(negedge clk);
      waited++;
    end
    if (!bus.in_ready) begin
      compared++;
      mismatched++;
      $display("[TB] FAIL in_ready_timeout: got 0, expected 1");
      return;
    end
    bus.in_a     = W'(a);
    bus.in_b     = W'(b);
    bus.in_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    if (track) pushExpected(a, b);
  endtask

  task automatic drain();
    int n = 0;
    while (sb_q.size() != 0 && n < LIMIT) begin
      @(negedge clk);
      n++;
    end
    if (sb_q.size() != 0) begin
      compared++;
      mismatched++;
      $display("[TB] FAIL drain_timeout: got %0d pending, expected 0", sb_q.size());
      sb_q.delete();
    end
    @(negedge clk);
  endtask

  task automatic checkResetValues(input string tag);
    checkOutput({tag, "_in_ready"},  int'(bus.in_ready),  1);
    checkOutput({tag, "_out_valid"}, int'(bus.out_valid), 0);
    checkOutput({tag, "_busy"},      int'(bus.busy),      0);
    checkOutput({tag, "_out_gcd"},   int'(bus.out_gcd),   0);
    checkOutput({tag, "_out_steps"}, int'(bus.out_steps), 0);
  endtask

  // Monitor: compares each newly presented result against the oldest expectation.
  initial begin
    prev_valid = 1'b0;
    busy_cnt   = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_valid = 1'b0;
      end else begin
        if (bus.busy) busy_cnt++;
        if (bus.out_valid && !prev_valid) begin
          if (sb_q.size() == 0) begin
            compared++;
            mismatched++;
            $display("[TB] FAIL unexpected_result: got gcd %0d, expected no result", bus.out_gcd);
          end else begin
            exp_t e;
            e = sb_q.pop_front();
            checkOutput("out_gcd",   int'(bus.out_gcd),   int'(e.gcd));
            checkOutput("out_steps", int'(bus.out_steps), int'(e.steps));
            checkOutput("latency",   cycle - e.accept_cycle + 1, int'(e.steps) + 2);
            checkOutput("busy_cycles", busy_cnt, int'(e.steps) + 1);
          end
        end
        prev_valid = bus.out_valid;
      end
    end
  end

  // Main stimulus sequence.
  initial begin
    int waited;
    int a, b;
    cycle         = 0;
    compared      = 0;
    mismatched    = 0;
    rst_n         = 1'b0;
    bus.clear     = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_a      = '0;
    bus.in_b      = '0;
    bus.out_ready = 1'b1;
    repeat (3) @(negedge clk);
    checkResetValues("por");
    rst_n = 1'b1;

    // Directed pairs including equal, zero and worst-case operands.
    applyStimulus(12, 8, 1);   drain();
    applyStimulus(255, 1, 1);  drain();
    applyStimulus(1, 255, 1);  drain();
    applyStimulus(0, 9, 1);    drain();
    applyStimulus(9, 0, 1);    drain();
    applyStimulus(0, 0, 1);    drain();
    applyStimulus(7, 7, 1);    drain();

    // Back-pressure: result must hold and new operands must be ignored.
    bus.out_ready = 1'b0;
    applyStimulus(21, 14, 1);
    waited = 0;
    while (!bus.out_valid && waited < LIMIT) begin
      @(negedge clk);
      waited++;
    end
    bus.in_a     = W'(30);
    bus.in_b     = W'(18);
    bus.in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      checkOutput("bp_out_valid", int'(bus.out_valid), 1);
      checkOutput("bp_in_ready",  int'(bus.in_ready),  0);
      checkOutput("bp_out_gcd",   int'(bus.out_gcd),   7);
      checkOutput("bp_out_steps", int'(bus.out_steps), 2);
    end
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("bp_release_valid", int'(bus.out_valid), 0);
    checkOutput("bp_release_ready", int'(bus.in_ready),  1);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    pushExpected(30, 18);
    checkOutput("bp_next_busy", int'(bus.busy), 1);
    drain();

    // Abort mid-calculation; no result may appear afterwards.
    applyStimulus(200, 3, 0);
    repeat (5) @(negedge clk);
    bus.clear = 1'b1;
    @(posedge clk);
    #1;
    bus.clear = 1'b0;
    checkOutput("clr_in_ready", int'(bus.in_ready), 1);
    checkOutput("clr_busy",     int'(bus.busy),     0);
    repeat (300) @(negedge clk);
    checkOutput("clr_out_valid", int'(bus.out_valid), 0);

    // Clear wins over a same-cycle accept.
    bus.in_a     = W'(5);
    bus.in_b     = W'(5);
    bus.in_valid = 1'b1;
    bus.clear    = 1'b1;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.clear    = 1'b0;
    checkOutput("clr_prio_busy",     int'(bus.busy),     0);
    checkOutput("clr_prio_in_ready", int'(bus.in_ready), 1);
    repeat (4) @(negedge clk);
    applyStimulus(10, 4, 1);   drain();

    // Asynchronous reset mid-calculation.
    applyStimulus(200, 3, 0);
    repeat (4) @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checkResetValues("rst");
    @(negedge clk);
    rst_n = 1'b1;
    applyStimulus(18, 12, 1);  drain();

    // Randomised pairs with idle gaps.
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        a = $urandom_range(0, 15);
        b = $urandom_range(0, 15);
      end else begin
        a = $urandom_range(0, 255);
        b = $urandom_range(1, 255);
      end
      applyStimulus(a, b, 1);
      drain();
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end

    drain();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
